uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised, buffered UART transmitter for the UART-AXI4 bridge. It accepts bytes over a valid/ready stream into an internal FIFO and serialises them LSB-first on `uart_tx`. The baud divisor, data width (5–8 bits), parity (none/even/odd) and stop bits (1/2) are configurable at run time, and back-to-back frames go out with no idle gap. It replaces the fixed 8N1 single-byte transmitter in the bridge's response path and adds `tx_en` flow control (e.g. from CTS).

## Interface
- `DIV_WIDTH`, 16, width of the clocks-per-bit divisor input.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_baud_div`  in  DIV_WIDTH  clocks per bit; values 0 and 1 are treated as 2.
- `cfg_data_bits`  in  2  data width: 0=5, 1=6, 2=7, 3=8 bits.
- `cfg_parity`  in  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
- `cfg_stop2`  in  1  1 = two stop bits, 0 = one.
- `tx_en`  in  1  permits starting a new frame.
- `s_data`  in  8  byte to send; bits above the configured width are ignored.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  = !FIFO full.
- `uart_tx`  out  1  serial line, registered, idles high.
- `tx_busy`  out  1  a frame is in progress (state != IDLE).
- `tx_done`  out  1  one-cycle pulse after each frame's final stop-bit cycle.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO write on `s_valid && s_ready`. There is no write-through bypass.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when FIFO is non-empty and `tx_en`=1. In the same cycle:
  - pop the head entry into the shift register;
  - latch all `cfg_*` inputs for the frame;
  - load the bit counter with n−1;
  - clear the baud counter.
- Baud counter counts 0..D−1, where D is the effective divisor. The bit boundary is at count D−1. Every bit lasts exactly D clocks.
- START → DATA at the bit boundary.
- DATA: the line carries `shift[0]`. At each boundary, shift right and decrement the counter. After bit n−1:
  - go to PARITY if parity is enabled;
  - otherwise go to STOP.
- PARITY: the bit is the XOR of the n data bits (even), or its inverse (odd). → STOP at the boundary.
- STOP: line high for 1 or 2 bit times. At the final boundary:
  - → START (immediate pop) if FIFO is non-empty and `tx_en`=1;
  - otherwise → IDLE.
- `cfg_*` changes during a frame have no effect until the next pop.
- `tx_en` falling mid-frame: the current frame completes, and no new frame starts.
- Push and pop in the same cycle: level unchanged. Push while full: blocked by `s_ready`=0, even if a pop occurs that cycle.

## Timing
- Reset values: `uart_tx`=1, `s_ready`=1, `tx_busy`=0, `tx_done`=0, `fifo_level`=0. The FIFO is emptied and the state is IDLE.
- Reset mid-frame: `uart_tx` goes high asynchronously, and the queued data is discarded.
- Write accepted at edge N into an empty FIFO while idle with `tx_en`=1:
  - pop and START at edge N+1;
  - `uart_tx` low from edge N+2.
- Frame length is exactly (1 + n + p + s) × D clocks, where p∈{0,1} and s∈{1,2}.
- `uart_tx` is registered, so it lags the state by one clock, uniformly for all bits.
- `tx_done` is high for the single cycle after the last stop-bit cycle, aligned with the first `uart_tx` cycle of the next start bit or return to idle.
- Back-to-back frames: zero idle clocks between the last stop bit and the next start bit.
- `s_ready` and `fifo_level` reflect the registered FIFO state; `s_ready` rises the cycle after a pop from full.

## Test plan
- 8N1, D=4, push 0xA5 → `uart_tx` carries 0, 1,0,1,0,0,1,0,1, 1; each bit 4 clocks, 40 clocks total; one `tx_done` pulse; `tx_busy` high for 40 cycles.
- 7E2, D=4, push 0x41 → 0, 1,0,0,0,0,0,1, parity 0, 1,1; 44 clocks. Then 5-bit odd with 0x1F → 0, 1,1,1,1,1, parity 0, 1; 32 clocks.
- `FIFO_DEPTH`=4, `tx_en`=0, push 5 bytes → 4 accepted; `s_ready`=0 at level 4. The 5th is held until `tx_en`=1, then all 5 go out in order with no idle gaps.
- Back-to-back 0x00 then 0xFF, 8N1, D=2:
  - exactly 1 `tx_done` per frame;
  - the second start bit immediately follows the first stop bit;
  - `cfg_baud_div` change to 3 mid-frame 1 applies only from frame 2.
- `cfg_baud_div`=0 → identical waveform to D=2.
- Assert `rst_n`=0 mid-DATA with 3 bytes queued → `uart_tx`=1 immediately and `fifo_level`=0. After release, nothing transmits until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with per-frame runtime config
module uart_tx_fifo #(
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_WIDTH-1:0]        cfg_baud_div,
  input  logic [1:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        tx_en,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        uart_tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shift, dm;
  logic [2:0] bit_cnt;
  logic [DIV_WIDTH-1:0] baud_cnt, div_r, div_eff;
  logic par_en, par_bit, stop_cnt, done_pend, push, pop, tick, last_stop;
  assign s_ready   = fifo_level != FULL;
  assign push      = s_valid && s_ready;
  assign tx_busy   = state != IDLE;
  assign div_eff   = cfg_baud_div < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : cfg_baud_div;
  assign tick      = baud_cnt == div_r - DIV_WIDTH'(1);
  assign last_stop = state == STOP && tick && !stop_cnt;
  assign pop       = (state == IDLE || last_stop) && tx_en && fifo_level != '0;
  // Bits above the configured width are cleared so parity covers only sent bits
  assign dm        = mem[rd_ptr] & (8'hFF >> (2'd3 - cfg_data_bits));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      div_r     <= DIV_WIDTH'(2);
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      stop_cnt  <= 1'b0;
      uart_tx   <= 1'b1;
      done_pend <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      uart_tx   <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
      done_pend <= last_stop;
      tx_done   <= done_pend;
      baud_cnt  <= (tick || state == IDLE) ? '0 : baud_cnt + DIV_WIDTH'(1);
      if (pop) begin
        state    <= START;
        shift    <= dm;
        bit_cnt  <= {1'b1, cfg_data_bits};
        baud_cnt <= '0;
        div_r    <= div_eff;
        par_en   <= ^cfg_parity;
        par_bit  <= ^dm ^ cfg_parity[1];
        stop_cnt <= cfg_stop2;
      end else if (tick)
        case (state)
          START: state <= DATA;
          DATA: begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) state <= par_en ? PARITY : STOP;
          end
          PARITY: state <= STOP;
          STOP: begin
            stop_cnt <= 1'b0;
            if (!stop_cnt) state <= IDLE;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: table-driven frame vectors plus scoreboarded multi-frame sequences
module tb_uart_tx_fifo;
  logic clk = 0, rst_n = 0;
  logic [15:0] cfg_baud_div = 16'd4;
  logic [1:0] cfg_data_bits = 2'd3, cfg_parity = 2'd0;
  logic cfg_stop2 = 0, tx_en = 1, s_valid = 0;
  logic [7:0] s_data = 0;
  logic s_ready, uart_tx, tx_busy, tx_done;
  logic [2:0] fifo_level;
  int errs = 0, checks = 0, busy_cnt = 0, done_cnt = 0;
  typedef struct {int d; int nb; logic [11:0] bits;} exp_t;
  typedef struct {logic [7:0] data; logic [1:0] dbits; logic [1:0] par; logic stop2;
                  logic [15:0] div; int d; int nb; logic [11:0] bits;} vec_t;
  exp_t sb[$];
  vec_t vecs[9];

  uart_tx_fifo #(.DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_baud_div(cfg_baud_div), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx_en(tx_en), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .uart_tx(uart_tx), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_level(fifo_level));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (tx_busy) busy_cnt <= busy_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] frame8n1(input logic [7:0] b);
    return {3'b001, b, 1'b0};
  endfunction

  task automatic expect_frame(input int d, input int nb, input logic [11:0] bits);
    exp_t e;
    e = '{d, nb, bits};
    sb.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] b, output bit ok);
    bit acc;
    ok = 0;
    s_data = b;
    s_valid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      acc = s_ready;
      @(negedge clk);
      ok = acc;
    end
    s_valid = 0;
  endtask

  // Waits for a start bit, then checks n contiguous frames cycle by cycle
  task automatic check_frames(input int n, input bit lat);
    int wait_n, bad;
    exp_t e;
    wait_n = 0;
    while (uart_tx === 1'b1 && wait_n < 300) begin
      @(negedge clk);
      wait_n++;
    end
    if (uart_tx !== 1'b0) begin
      chk("start_timeout", uart_tx, 0);
      return;
    end
    if (lat) chk("start_latency", wait_n, 2);
    for (int f = 0; f < n; f++) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
        return;
      end
      e = sb.pop_front();
      bad = 0;
      for (int i = 0; i < e.nb; i++)
        for (int j = 0; j < e.d; j++) begin
          if (uart_tx !== e.bits[i]) bad++;
          @(negedge clk);
        end
      chk($sformatf("frame%0d_bad_cycles", f), bad, 0);
      chk($sformatf("frame%0d_done_align", f), tx_done, 1);
    end
  endtask

  initial begin
    bit ok;
    int b0, d0, lows;
    logic [7:0] fill [4];
    vecs[0] = '{8'hA5, 2'd3, 2'd0, 1'b0, 16'd4, 4, 10, 12'h34A};
    vecs[1] = '{8'h41, 2'd2, 2'd1, 1'b1, 16'd4, 4, 11, 12'h682};
    vecs[2] = '{8'h1F, 2'd0, 2'd2, 1'b0, 16'd4, 4, 8,  12'h0BE};
    vecs[3] = '{8'h5A, 2'd3, 2'd0, 1'b0, 16'd0, 2, 10, 12'h2B4};
    vecs[4] = '{8'h5A, 2'd3, 2'd0, 1'b0, 16'd2, 2, 10, 12'h2B4};
    vecs[5] = '{8'hFC, 2'd1, 2'd1, 1'b0, 16'd1, 2, 9,  12'h178};
    vecs[6] = '{8'h00, 2'd3, 2'd2, 1'b1, 16'd3, 3, 12, 12'hE00};
    vecs[7] = '{8'hE3, 2'd0, 2'd3, 1'b0, 16'd5, 5, 7,  12'h046};
    vecs[8] = '{8'h07, 2'd3, 2'd1, 1'b0, 16'd2, 2, 11, 12'h60E};
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_level", fifo_level, 0);

    foreach (vecs[k]) begin
      cfg_data_bits = vecs[k].dbits;
      cfg_parity    = vecs[k].par;
      cfg_stop2     = vecs[k].stop2;
      cfg_baud_div  = vecs[k].div;
      expect_frame(vecs[k].d, vecs[k].nb, vecs[k].bits);
      b0 = busy_cnt;
      d0 = done_cnt;
      push_byte(vecs[k].data, ok);
      chk($sformatf("v%0d_push", k), ok, 1);
      check_frames(1, 1);
      @(negedge clk);
      chk($sformatf("v%0d_busy_cycles", k), busy_cnt - b0, vecs[k].d * vecs[k].nb);
      chk($sformatf("v%0d_done_pulses", k), done_cnt - d0, 1);
    end

    // Fill a 4-deep FIFO with tx disabled, hold a 5th byte, then release
    tx_en = 0;
    cfg_data_bits = 2'd3;
    cfg_parity = 2'd0;
    cfg_stop2 = 0;
    cfg_baud_div = 16'd2;
    foreach (fill[k]) begin
      expect_frame(2, 10, frame8n1(fill[k]));
      push_byte(fill[k], ok);
      chk("fill_push", ok, 1);
    end
    chk("full_level", fifo_level, 4);
    chk("full_ready", s_ready, 0);
    s_data = 8'h55;
    s_valid = 1;
    repeat (3) @(negedge clk);
    chk("full_block", fifo_level, 4);
    chk("full_idle_line", uart_tx, 1);
    expect_frame(2, 10, frame8n1(8'h55));
    d0 = done_cnt;
    fork
      begin
        tx_en = 1;
        @(negedge clk);
        chk("pop_ready", s_ready, 1);
        chk("pop_level", fifo_level, 3);
        push_byte(8'h55, ok);
        chk("fifth_push", ok, 1);
      end
      check_frames(5, 0);
    join
    @(negedge clk);
    chk("burst_done_pulses", done_cnt - d0, 5);
    chk("burst_level", fifo_level, 0);

    // Back-to-back with a divisor change during the first frame
    expect_frame(2, 10, frame8n1(8'h00));
    expect_frame(3, 10, frame8n1(8'hFF));
    d0 = done_cnt;
    push_byte(8'h00, ok);
    push_byte(8'hFF, ok);
    fork
      begin
        repeat (6) @(negedge clk);
        cfg_baud_div = 16'd3;
      end
      check_frames(2, 0);
    join
    @(negedge clk);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    // Reset in the middle of a data bit with three bytes still queued
    tx_en = 0;
    cfg_baud_div = 16'd4;
    repeat (4) push_byte(8'h00, ok);
    chk("pre_rst_level4", fifo_level, 4);
    tx_en = 1;
    repeat (8) @(negedge clk);
    chk("pre_rst_line_low", uart_tx, 0);
    chk("pre_rst_level3", fifo_level, 3);
    #2 rst_n = 0;
    #1;
    chk("async_rst_line", uart_tx, 1);
    chk("async_rst_level", fifo_level, 0);
    chk("async_rst_busy", tx_busy, 0);
    chk("async_rst_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1;
    d0 = done_cnt;
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("post_rst_quiet", lows, 0);
    chk("post_rst_done", done_cnt - d0, 0);
    chk("post_rst_level", fifo_level, 0);
    expect_frame(4, 10, frame8n1(8'h96));
    push_byte(8'h96, ok);
    check_frames(1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
